// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU and its exception unit:
// ALU control codes, status-word bit positions, exception cause codes
// and the exception FSM state encoding.
package alu_pkg;

    localparam int unsigned CTRL_W   = 4;
    localparam int unsigned STATUS_W = 8;
    localparam int unsigned CAUSE_W  = 5;
    localparam int unsigned XLEN     = 32;

    // ALU control codes
    localparam logic [CTRL_W-1:0] ALU_AND  = 4'd0;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'd1;
    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'd2;
    localparam logic [CTRL_W-1:0] ALU_ADDU = 4'd3;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'd4;
    localparam logic [CTRL_W-1:0] ALU_SUBU = 4'd5;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'd6;
    localparam logic [CTRL_W-1:0] ALU_XOR  = 4'd7;
    localparam logic [CTRL_W-1:0] ALU_NOR  = 4'd8;
    localparam logic [CTRL_W-1:0] ALU_SLL  = 4'd9;
    localparam logic [CTRL_W-1:0] ALU_SRL  = 4'd10;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 4'd11;
    localparam logic [CTRL_W-1:0] ALU_MUL  = 4'd12;
    localparam logic [CTRL_W-1:0] ALU_DIV  = 4'd13;
    localparam logic [CTRL_W-1:0] ALU_DIVU = 4'd14;
    localparam logic [CTRL_W-1:0] ALU_LUI  = 4'd15;

    // Status word bit positions; bits [1:0] are reserved
    localparam int unsigned ST_Z   = 7;
    localparam int unsigned ST_V   = 6;
    localparam int unsigned ST_C   = 5;
    localparam int unsigned ST_N   = 4;
    localparam int unsigned ST_ODD = 3;
    localparam int unsigned ST_DZ  = 2;

    // Reserved bits never reach the flag registers
    localparam logic [STATUS_W-1:0] STATUS_MASK = 8'hFC;

    // Exception cause codes
    localparam logic [CAUSE_W-1:0] CAUSE_OV = 5'd12;
    localparam logic [CAUSE_W-1:0] CAUSE_DZ = 5'd16;

    typedef enum logic [1:0] {
        EXC_IDLE     = 2'd0,
        EXC_FLUSH    = 2'd1,
        EXC_WAIT_ACK = 2'd2
    } exc_state_e;

    // Divide-by-zero outranks overflow when both trap in the same op
    function automatic logic [CAUSE_W-1:0] trap_cause(input logic dz_trap);
        return dz_trap ? CAUSE_DZ : CAUSE_OV;
    endfunction

endpackage

// File: rtl/alu_exception_unit_sat_counter.sv
// Saturating event counter.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count one event (holds at all-ones)
//   clr      : zero the counter; wins over inc
//   q        : current count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/alu_exception_unit.sv
// EX-stage ALU status consumer: latches flags, keeps sticky flags and
// saturating V/DZ event counters, and raises a precise exception with
// cause and EPC for trapping overflow / divide-by-zero, flushing and
// stalling the pipeline until the control unit acknowledges.
//   clk, rst     : clock, synchronous active-high reset
//   alu_valid    : ALU result valid this cycle
//   alu_ctrl     : ALU control code (informational here)
//   alu_status   : {Z,V,C,N,odd,DZ,rsvd[1:0]}
//   ovf_trap_en  : instruction traps on V
//   pc_ex        : PC of the EX instruction
//   status_clr   : clear sticky flags and counters
//   exc_ack      : handler has been entered
//   flags_q      : flags of the last accepted op
//   sticky_q     : OR of accepted flags since reset/clear
//   exc_req      : exception pending
//   exc_cause    : cause code
//   epc          : faulting PC
//   flush        : one-cycle kill of IF/ID/EX
//   stall        : high whenever not IDLE
//   ovf_cnt      : saturating count of accepted V events
//   dz_cnt       : saturating count of accepted DZ events
module alu_exception_unit
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter bit          DZ_TRAP_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    input  logic [CTRL_W-1:0]   alu_ctrl,
    input  logic [STATUS_W-1:0] alu_status,
    input  logic                ovf_trap_en,
    input  logic [XLEN-1:0]     pc_ex,
    input  logic                status_clr,
    input  logic                exc_ack,
    output logic [STATUS_W-1:0] flags_q,
    output logic [STATUS_W-1:0] sticky_q,
    output logic                exc_req,
    output logic [CAUSE_W-1:0]  exc_cause,
    output logic [XLEN-1:0]     epc,
    output logic                flush,
    output logic                stall,
    output logic [CNT_W-1:0]    ovf_cnt,
    output logic [CNT_W-1:0]    dz_cnt
);

    exc_state_e          state_q, state_d;
    logic [STATUS_W-1:0] flags_d, sticky_d, sticky_r_q;
    logic [STATUS_W-1:0] flags_r_q;
    logic [CAUSE_W-1:0]  cause_q, cause_d;
    logic [XLEN-1:0]     epc_q, epc_d;
    logic                exc_req_q, exc_req_d;
    logic                flush_q, flush_d;
    logic                stall_q, stall_d;

    logic                accept_c;
    logic                trap_dz_c;
    logic                trap_ov_c;
    logic [STATUS_W-1:0] status_m_c;

    // The control code does not influence trapping; trap enables arrive decoded
    logic                unused_alu_ctrl;
    assign unused_alu_ctrl = ^alu_ctrl;

    // Ops are only taken while no exception is in flight
    assign accept_c   = alu_valid && (state_q == EXC_IDLE);
    assign status_m_c = alu_status & STATUS_MASK;
    assign trap_dz_c  = accept_c && alu_status[ST_DZ] && DZ_TRAP_EN;
    assign trap_ov_c  = accept_c && alu_status[ST_V] && ovf_trap_en;

    // Next state, capture registers and flag registers
    always_comb begin
        state_d   = state_q;
        flags_d   = flags_r_q;
        sticky_d  = status_clr ? '0 : sticky_r_q;
        cause_d   = cause_q;
        epc_d     = epc_q;
        exc_req_d = 1'b0;
        flush_d   = 1'b0;
        stall_d   = 1'b0;

        if (accept_c) begin
            flags_d  = status_m_c;
            sticky_d = sticky_d | status_m_c;
        end

        case (state_q)
            EXC_IDLE: begin
                if (trap_dz_c || trap_ov_c) begin
                    state_d = EXC_FLUSH;
                    epc_d   = pc_ex;
                    cause_d = trap_cause(trap_dz_c);
                end
            end
            // Ack cannot be meaningful before the flush has been issued
            EXC_FLUSH: state_d = EXC_WAIT_ACK;
            EXC_WAIT_ACK: begin
                if (exc_ack) begin
                    state_d = EXC_IDLE;
                end
            end
            default: state_d = EXC_IDLE;
        endcase

        // Outputs are registered versions of the next-state decode
        exc_req_d = (state_d != EXC_IDLE);
        flush_d   = (state_d == EXC_FLUSH);
        stall_d   = (state_d != EXC_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EXC_IDLE;
            flags_r_q  <= '0;
            sticky_r_q <= '0;
            cause_q    <= '0;
            epc_q      <= '0;
            exc_req_q  <= 1'b0;
            flush_q    <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            flags_r_q  <= flags_d;
            sticky_r_q <= sticky_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            exc_req_q  <= exc_req_d;
            flush_q    <= flush_d;
            stall_q    <= stall_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_ovf_cnt (
        .clk (clk),
        .rst (rst),
        .inc (accept_c && alu_status[ST_V]),
        .clr (status_clr),
        .q   (ovf_cnt)
    );

    sat_counter #(.W(CNT_W)) u_dz_cnt (
        .clk (clk),
        .rst (rst),
        .inc (accept_c && alu_status[ST_DZ]),
        .clr (status_clr),
        .q   (dz_cnt)
    );

    assign flags_q   = flags_r_q;
    assign sticky_q  = sticky_r_q;
    assign exc_req   = exc_req_q;
    assign exc_cause = cause_q;
    assign epc       = epc_q;
    assign flush     = flush_q;
    assign stall     = stall_q;

endmodule

// File: tb/tb_alu_exception_unit.sv
// Self-checking bench for alu_exception_unit: directed scenarios followed
// by random traffic, every cycle compared against a behavioural model.
module tb_alu_exception_unit;

    localparam int unsigned CNT_W = 8;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_ctrl;
    logic [7:0]  alu_status;
    logic        ovf_trap_en;
    logic [31:0] pc_ex;
    logic        status_clr;
    logic        exc_ack;
    logic [7:0]  flags_q;
    logic [7:0]  sticky_q;
    logic        exc_req;
    logic [4:0]  exc_cause;
    logic [31:0] epc;
    logic        flush;
    logic        stall;
    logic [CNT_W-1:0] ovf_cnt;
    logic [CNT_W-1:0] dz_cnt;

    always #5 clk = ~clk;

    alu_exception_unit #(.CNT_W(CNT_W), .DZ_TRAP_EN(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_ctrl    (alu_ctrl),
        .alu_status  (alu_status),
        .ovf_trap_en (ovf_trap_en),
        .pc_ex       (pc_ex),
        .status_clr  (status_clr),
        .exc_ack     (exc_ack),
        .flags_q     (flags_q),
        .sticky_q    (sticky_q),
        .exc_req     (exc_req),
        .exc_cause   (exc_cause),
        .epc         (epc),
        .flush       (flush),
        .stall       (stall),
        .ovf_cnt     (ovf_cnt),
        .dz_cnt      (dz_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 = running, 1 = flushing, 2 = waiting for ack
    int          m_phase;
    logic [7:0]  m_flags;
    logic [7:0]  m_sticky;
    int          m_ovf;
    int          m_dz;
    logic [4:0]  m_cause;
    logic [31:0] m_epc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_flags  = 8'h00;
        m_sticky = 8'h00;
        m_ovf    = 0;
        m_dz     = 0;
        m_cause  = 5'd0;
        m_epc    = 32'h0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".flags"},  32'(flags_q),   32'(m_flags));
        check({tag, ".sticky"}, 32'(sticky_q),  32'(m_sticky));
        check({tag, ".exc_req"},32'(exc_req),   32'(m_phase != 0));
        check({tag, ".flush"},  32'(flush),     32'(m_phase == 1));
        check({tag, ".stall"},  32'(stall),     32'(m_phase != 0));
        check({tag, ".ovf_cnt"},32'(ovf_cnt),   32'(m_ovf));
        check({tag, ".dz_cnt"}, 32'(dz_cnt),    32'(m_dz));
        check({tag, ".cause"},  32'(exc_cause), 32'(m_cause));
        check({tag, ".epc"},    epc,            m_epc);
    endtask

    // Drive one cycle of inputs, advance the model, compare every output
    task automatic step(input string tag, input logic r, input logic v, input logic [7:0] st,
                        input logic ote, input logic [31:0] pc, input logic clr, input logic ack);
        bit acc, dz_t, ov_t;
        rst         = r;
        alu_valid   = v;
        alu_ctrl    = 4'($urandom_range(0, 15));
        alu_status  = st;
        ovf_trap_en = ote;
        pc_ex       = pc;
        status_clr  = clr;
        exc_ack     = ack;
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            acc  = v && (m_phase == 0);
            dz_t = acc && st[2];
            ov_t = acc && st[6] && ote;
            if (clr) begin
                m_sticky = 8'h00;
                m_ovf    = 0;
                m_dz     = 0;
            end
            if (acc) begin
                m_flags  = {st[7:2], 2'b00};
                m_sticky = m_sticky | m_flags;
                if (!clr && st[6]) m_ovf = (m_ovf < CMAX) ? m_ovf + 1 : CMAX;
                if (!clr && st[2]) m_dz  = (m_dz  < CMAX) ? m_dz  + 1 : CMAX;
            end
            case (m_phase)
                0: if (dz_t || ov_t) begin
                       m_phase = 1;
                       m_epc   = pc;
                       m_cause = dz_t ? 5'd16 : 5'd12;
                   end
                1: m_phase = 2;
                default: if (ack) m_phase = 0;
            endcase
        end
        check_all(tag);
    endtask

    initial begin
        model_reset();
        // Reset and idle
        step("rst0", 1, 0, 8'h00, 0, 32'h0, 0, 0);
        step("rst1", 1, 0, 8'h00, 0, 32'h0, 0, 0);
        step("idle", 0, 0, 8'h00, 0, 32'h0, 0, 0);

        // Reset while waiting for ack
        step("t1_trap", 0, 1, 8'h40, 1, 32'h0000_1000, 0, 0);
        step("t1_fl",   0, 0, 8'h00, 0, 32'h0, 0, 0);
        step("t1_wait", 0, 0, 8'h00, 0, 32'h0, 0, 0);
        step("t1_rst",  1, 0, 8'h00, 0, 32'h0, 0, 0);
        check("t1_exc_req", 32'(exc_req), 32'h0);
        check("t1_sticky",  32'(sticky_q), 32'h0);
        check("t1_ovf",     32'(ovf_cnt), 32'h0);

        // Plain Z result, reserved bits dropped
        step("t2_z", 0, 1, 8'h83, 0, 32'h0, 0, 0);
        check("t2_flags", 32'(flags_q), 32'h80);
        check("t2_sticky", 32'(sticky_q), 32'h80);

        // Overflow trap with latency and ack handshake; ack in FLUSH ignored
        step("t3_acc",  0, 1, 8'h40, 1, 32'h0040_0010, 0, 0);
        check("t3_flush", 32'(flush), 32'h1);
        check("t3_cause", 32'(exc_cause), 32'd12);
        check("t3_epc",   epc, 32'h0040_0010);
        step("t3_flack", 0, 1, 8'h04, 0, 32'h0, 0, 1);
        check("t3_stall", 32'(stall), 32'h1);
        step("t3_wait", 0, 0, 8'h00, 0, 32'h0, 0, 0);
        step("t3_ack",  0, 0, 8'h00, 0, 32'h0, 0, 1);
        check("t3_idle", 32'(exc_req), 32'h0);
        check("t3_epc_hold", epc, 32'h0040_0010);

        // DZ beats V
        step("t4_clr", 0, 0, 8'h00, 0, 32'h0, 1, 0);
        step("t4_acc", 0, 1, 8'h44, 1, 32'h0040_0020, 0, 0);
        check("t4_cause", 32'(exc_cause), 32'd16);
        check("t4_ovf", 32'(ovf_cnt), 32'd1);
        check("t4_dz",  32'(dz_cnt), 32'd1);
        // Ops during FLUSH/WAIT_ACK ignored, then back-to-back accept on ack
        step("t6_fl",   0, 1, 8'h04, 1, 32'hDEAD_0000, 0, 0);
        step("t6_wait", 0, 1, 8'h44, 1, 32'hDEAD_0004, 0, 0);
        check("t6_dz_hold", 32'(dz_cnt), 32'd1);
        step("t6_ack",  0, 1, 8'h10, 0, 32'h0, 0, 1);
        step("t6_b2b",  0, 1, 8'h10, 0, 32'h0, 0, 0);
        check("t6_b2b_flags", 32'(flags_q), 32'h10);
        // Clear together with an accept
        step("t6_clracc", 0, 1, 8'h28, 0, 32'h0, 1, 0);
        check("t6_sticky", 32'(sticky_q), 32'h28);

        // Non-trapping overflow saturates the counter
        for (int i = 0; i < 300; i++) begin
            step("t5_sat", 0, 1, 8'h40, 0, 32'h0, 0, 0);
        end
        check("t5_ovf_sat", 32'(ovf_cnt), 32'd255);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), ($urandom_range(0, 1) == 1), $urandom,
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
